// File: rtl/rmii_rx_dibit_align.sv
// RMII receive dibit aligner: pairs 2-bit RMII dibits into MII nibbles with a
// clock-enable strobe for the MAC receive path.
// Optional feature macro: RMII_RX_10M_EN builds the 10M mid-dibit sampler and
// honours mode_speed. Without it the block always runs at 100M.
module rmii_rx_dibit_align (
  input  logic       phy_rmii_ref_clk,
  input  logic       rstn,
  input  logic       mode_speed,
  input  logic       phy_rmii_crsdv,
  input  logic       phy_rmii_rxer,
  input  logic [1:0] phy_rmii_rxd,
  output logic [3:0] mac_mii_rxd,
  output logic       mac_mii_rxdv,
  output logic       mac_mii_rxer,
  output logic       mac_mii_rxce
);

  localparam int unsigned DIBIT_W  = 2;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_e;

  // Input stage
  logic               crsdv_in_q, crsdv_in_d;
  logic               rxer_in_q,  rxer_in_d;
  logic [DIBIT_W-1:0] rxd_in_q,   rxd_in_d;

  // Frame state
  state_e             state_q, state_d;
  logic               phase_q, phase_d;
  logic               pre_low_q, pre_low_d;
  logic [DIBIT_W-1:0] low_rxd_q, low_rxd_d;
  logic               low_crsdv_q, low_crsdv_d;
  logic               low_rxer_q, low_rxer_d;

  // Output registers
  logic [NIBBLE_W-1:0] rxd_q, rxd_d;
  logic                rxdv_q, rxdv_d;
  logic                rxer_q, rxer_d;
  logic                rxce_q, rxce_d;

  logic strobe_c;

  // Single register stage on the RMII pins; all decisions use these copies
  always_comb begin
    crsdv_in_d = phy_rmii_crsdv;
    rxer_in_d  = phy_rmii_rxer;
    rxd_in_d   = phy_rmii_rxd;
  end

`ifdef RMII_RX_10M_EN
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned DIV_MAX = 9;
  localparam int unsigned DIV_MID = 4;

  logic             speed_q, speed_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Speed is only picked up between frames; 10M samples at count 4, mid-dibit
  always_comb begin
    speed_d  = (state_q == ST_IDLE) ? mode_speed : speed_q;
    strobe_c = speed_q || (div_cnt_q == DIV_W'(DIV_MID));
  end

  // Divider held at 0 while idle without carrier so the first carrier cycle
  // starts the dibit period at 0; also restarts whenever a frame ends
  always_comb begin
    div_cnt_d = div_cnt_q;
    if ((state_q == ST_IDLE) && !crsdv_in_q) begin
      div_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_W'(DIV_MAX)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider and speed registers
  always_ff @(posedge phy_rmii_ref_clk) begin
    if (!rstn) begin
      speed_q   <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      speed_q   <= speed_d;
      div_cnt_q <= div_cnt_d;
    end
  end
`else
  logic unused_mode_speed;

  // Fixed 100M operation: every cycle is a sample cycle
  always_comb begin
    strobe_c          = 1'b1;
    unused_mode_speed = mode_speed;
  end
`endif

  // Next-state and nibble assembly; only sample cycles advance the frame
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pre_low_d   = pre_low_q;
    low_rxd_d   = low_rxd_q;
    low_crsdv_d = low_crsdv_q;
    low_rxer_d  = low_rxer_q;
    rxd_d       = rxd_q;
    rxdv_d      = rxdv_q;
    rxer_d      = rxer_q;
    rxce_d      = 1'b0;

    if (strobe_c) begin
      unique case (state_q)
        ST_IDLE: begin
          phase_d   = 1'b0;
          pre_low_d = 1'b0;
          if (crsdv_in_q) begin
            state_d = ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (!crsdv_in_q) begin
            // Two consecutive carrier-less samples abandon the false start
            if (pre_low_q) begin
              state_d   = ST_IDLE;
              pre_low_d = 1'b0;
            end else begin
              pre_low_d = 1'b1;
            end
          end else begin
            pre_low_d = 1'b0;
            // First 01 locks nibble alignment and becomes the low half
            if (rxd_in_q == 2'b01) begin
              state_d     = ST_DATA;
              phase_d     = 1'b1;
              low_rxd_d   = rxd_in_q;
              low_crsdv_d = 1'b1;
              low_rxer_d  = rxer_in_q;
            end
          end
        end

        ST_DATA: begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            low_rxd_d   = rxd_in_q;
            low_crsdv_d = crsdv_in_q;
            low_rxer_d  = rxer_in_q;
          end else begin
            rxce_d = 1'b1;
            // Carrier toggling on one dibit is drain; both low ends the frame
            if (!low_crsdv_q && !crsdv_in_q) begin
              rxd_d   = '0;
              rxdv_d  = 1'b0;
              rxer_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              rxd_d  = {rxd_in_q, low_rxd_q};
              rxdv_d = 1'b1;
              rxer_d = low_rxer_q | rxer_in_q;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, input and output registers with synchronous reset
  always_ff @(posedge phy_rmii_ref_clk) begin
    if (!rstn) begin
      crsdv_in_q  <= 1'b0;
      rxer_in_q   <= 1'b0;
      rxd_in_q    <= '0;
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      pre_low_q   <= 1'b0;
      low_rxd_q   <= '0;
      low_crsdv_q <= 1'b0;
      low_rxer_q  <= 1'b0;
      rxd_q       <= '0;
      rxdv_q      <= 1'b0;
      rxer_q      <= 1'b0;
      rxce_q      <= 1'b0;
    end else begin
      crsdv_in_q  <= crsdv_in_d;
      rxer_in_q   <= rxer_in_d;
      rxd_in_q    <= rxd_in_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      pre_low_q   <= pre_low_d;
      low_rxd_q   <= low_rxd_d;
      low_crsdv_q <= low_crsdv_d;
      low_rxer_q  <= low_rxer_d;
      rxd_q       <= rxd_d;
      rxdv_q      <= rxdv_d;
      rxer_q      <= rxer_d;
      rxce_q      <= rxce_d;
    end
  end

  assign mac_mii_rxd  = rxd_q;
  assign mac_mii_rxdv = rxdv_q;
  assign mac_mii_rxer = rxer_q;
  assign mac_mii_rxce = rxce_q;

endmodule

// File: tb/tb_rmii_rx_dibit_align.sv
// Bench for rmii_rx_dibit_align: frames are described as nibble lists with
// per-dibit CRS_DV / RX_ER, serialised onto the RMII pins, and every MII
// output cycle is checked against the nibble sequence those frames imply.
`timescale 1ns/1ps
module tb_rmii_rx_dibit_align;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       mode_speed = 1'b1;
  logic       crsdv = 1'b0;
  logic       rxer = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic [3:0] mii_rxd;
  logic       mii_rxdv, mii_rxer, mii_rxce;

  always #10 clk = ~clk;

  rmii_rx_dibit_align dut (
    .phy_rmii_ref_clk (clk),
    .rstn             (rstn),
    .mode_speed       (mode_speed),
    .phy_rmii_crsdv   (crsdv),
    .phy_rmii_rxer    (rxer),
    .phy_rmii_rxd     (rxd),
    .mac_mii_rxd      (mii_rxd),
    .mac_mii_rxdv     (mii_rxdv),
    .mac_mii_rxer     (mii_rxer),
    .mac_mii_rxce     (mii_rxce)
  );

  // One nibble on the wire: dv/er bit 0 belongs to the low dibit
  typedef struct {
    logic [3:0] nib;
    logic [1:0] dv;
    logic [1:0] er;
  } nib_t;

  // One expected MII strobe
  typedef struct {
    logic [3:0] rxd;
    logic       dv;
    logic       er;
    int         cyc;
  } exp_t;

  nib_t frm[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dpc = 1;   // clock cycles per dibit
  int lat = 2;   // cycles from start of high dibit on the pins to rxce

  logic [3:0] hold_rxd = 4'h0;
  logic       hold_dv = 1'b0;
  logic       hold_er = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Apply one clock of pin values, then check what the DUT shows for that edge
  task automatic cycle(input logic n_rstn, input logic n_crsdv, input logic n_rxer,
                       input logic [1:0] n_rxd);
    logic rst_at_edge;
    exp_t e;
    @(posedge clk);
    #1;
    rst_at_edge = rstn;
    rstn  = n_rstn;
    crsdv = n_crsdv;
    rxer  = n_rxer;
    rxd   = n_rxd;
    cyc++;
    @(negedge clk);
    if (!rst_at_edge) begin
      chk("reset_outputs", 32'({mii_rxce, mii_rxdv, mii_rxer, mii_rxd}), 32'h0);
      chk("reset_pending_nibbles", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      hold_rxd = 4'h0;
      hold_dv  = 1'b0;
      hold_er  = 1'b0;
    end else if (mii_rxce) begin
      if (exp_q.size() == 0) begin
        chk("rxce_unexpected", 32'(mii_rxce), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rxce_cycle", 32'(cyc), 32'(e.cyc));
        chk("rxd", 32'(mii_rxd), 32'(e.rxd));
        chk("rxdv", 32'(mii_rxdv), 32'(e.dv));
        chk("rxer", 32'(mii_rxer), 32'(e.er));
        hold_rxd = e.rxd;
        hold_dv  = e.dv;
        hold_er  = e.er;
      end
    end else begin
      chk("hold", 32'({mii_rxdv, mii_rxer, mii_rxd}), 32'({hold_dv, hold_er, hold_rxd}));
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("rxce_missing", 32'(mii_rxce), 32'h1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic dibit(input logic c, input logic e, input logic [1:0] d);
    for (int i = 0; i < dpc; i++) cycle(1'b1, c, e, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dibit(1'b0, 1'b0, 2'b00);
  endtask

  function automatic void frm_nib(input logic [3:0] n, input logic [1:0] dv, input logic [1:0] er);
    nib_t x;
    x.nib = n;
    x.dv  = dv;
    x.er  = er;
    frm.push_back(x);
  endfunction

  function automatic void frm_preamble();
    frm.delete();
    for (int i = 0; i < 7; i++) frm_nib(4'h5, 2'b11, 2'b00);
    frm_nib(4'hD, 2'b11, 2'b00);
  endfunction

  function automatic void frm_byte(input logic [7:0] b);
    frm_nib(b[3:0], 2'b11, 2'b00);
    frm_nib(b[7:4], 2'b11, 2'b00);
  endfunction

  function automatic void frm_end();
    frm_nib(4'h0, 2'b00, 2'b00);
  endfunction

  // Serialise frm after `lead` carrier-only 00 dibits. Each nibble yields one
  // strobe: data if carrier was present on either dibit, else the end marker.
  // abort_at >= 0: drive that nibble's low dibit, then pulse reset.
  task automatic send_frame(input int lead, input int abort_at);
    exp_t e;
    for (int i = 0; i < lead; i++) dibit(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == abort_at) begin
        dibit(frm[i].dv[0], frm[i].er[0], frm[i].nib[1:0]);
        cycle(1'b0, 1'b1, 1'b0, frm[i].nib[3:2]);
        return;
      end
      e.dv  = |frm[i].dv;
      e.rxd = e.dv ? frm[i].nib : 4'h0;
      e.er  = e.dv ? |frm[i].er : 1'b0;
      e.cyc = cyc + 1 + dpc + lat;
      exp_q.push_back(e);
      dibit(frm[i].dv[0], frm[i].er[0], frm[i].nib[1:0]);
      dibit(frm[i].dv[1], frm[i].er[1], frm[i].nib[3:2]);
      if (!e.dv) break;
    end
  endtask

  task automatic std_frame();
    frm_preamble();
    frm_byte(8'h12);
    frm_byte(8'h34);
    frm_end();
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00);
    idle(4);

    // Basic 100M frame
    std_frame();
    send_frame(1, -1);
    idle(4);
    chk("basic_drained", 32'(exp_q.size()), 32'h0);

    // RX_ER on the high dibit of data nibble 0xA only
    frm_preamble();
    frm_byte(8'h5C);
    frm_nib(4'hA, 2'b11, 2'b10);
    frm_nib(4'h3, 2'b11, 2'b00);
    frm_byte(8'h96);
    frm_end();
    send_frame(2, -1);
    idle(3);
    chk("rxer_drained", 32'(exp_q.size()), 32'h0);

    // Carrier low on the low dibit only for the last 3 nibbles
    frm_preamble();
    frm_byte(8'h77);
    frm_nib(4'h1, 2'b10, 2'b00);
    frm_nib(4'h2, 2'b10, 2'b00);
    frm_nib(4'h3, 2'b10, 2'b00);
    frm_end();
    send_frame(1, -1);
    idle(3);
    chk("toggle_drained", 32'(exp_q.size()), 32'h0);

    // False start then a clean frame
    for (int i = 0; i < 4; i++) dibit(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) dibit(1'b0, 1'b0, 2'b00);
    idle(3);
    std_frame();
    send_frame(1, -1);
    idle(3);
    chk("false_start_drained", 32'(exp_q.size()), 32'h0);

    // Reset after 6 data nibbles, then a clean frame
    frm_preamble();
    frm_byte(8'h11);
    frm_byte(8'h22);
    frm_byte(8'h33);
    frm_byte(8'h44);
    frm_end();
    send_frame(1, 14);
    idle(5);
    std_frame();
    send_frame(1, -1);
    idle(3);
    chk("post_reset_drained", 32'(exp_q.size()), 32'h0);

    // Randomised frames: payload, carrier toggling on single dibits, RX_ER
    for (int f = 0; f < 6; f++) begin
      int nbytes;
      frm_preamble();
      nbytes = $urandom_range(2, 6);
      for (int b = 0; b < 2 * nbytes; b++) begin
        logic [1:0] dv;
        logic [1:0] er;
        dv = 2'($urandom_range(1, 3));
        er = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        frm_nib(4'($urandom_range(0, 15)), dv, er);
      end
      frm_end();
      send_frame($urandom_range(1, 3), -1);
      idle($urandom_range(2, 5));
      chk("random_drained", 32'(exp_q.size()), 32'h0);
    end

`ifdef RMII_RX_10M_EN
    // 10M: dibits held 10 cycles, strobes every 20
    mode_speed = 1'b0;
    idle(3);
    dpc = 10;
    lat = 6;
    std_frame();
    send_frame(1, -1);
    idle(3);
    chk("10m_drained", 32'(exp_q.size()), 32'h0);
    mode_speed = 1'b1;
    idle(2);
    dpc = 1;
    lat = 2;
    idle(3);
`else
    // mode_speed has no effect without the 10M divider
    mode_speed = 1'b0;
    idle(3);
    std_frame();
    send_frame(1, -1);
    idle(3);
    chk("speed_ignored_drained", 32'(exp_q.size()), 32'h0);
    mode_speed = 1'b1;
`endif

    std_frame();
    send_frame(1, -1);
    idle(4);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmii_rx_dibit_align.md
# rmii_rx_dibit_align

Receive-side RMII-to-MII converter for the 10M/100M MAC path. Samples 2-bit RMII dibits on the 50 MHz reference clock, locks to the preamble, pairs dibits into MII nibbles and decodes RMII CRS_DV carrier/data-valid toggling. Presents a nibble stream with a clock-enable strobe to the MAC receive logic (`eth_mac_1g` in MII mode, `rx_clk_enable` / `rx_mii_select`).

## Interface
- No HDL parameters; one compile-time macro (see Configuration).
- `phy_rmii_ref_clk`  in  1  50 MHz RMII reference clock; the only clock.
- `rstn`  in  1  synchronous, active-low reset.
- `mode_speed`  in  1  1 = 100M, 0 = 10M; latched in IDLE only.
- `phy_rmii_crsdv`  in  1  RMII CRS_DV.
- `phy_rmii_rxer`  in  1  RMII RX_ER.
- `phy_rmii_rxd`  in  2  RMII receive dibit, bit 0 first on the wire.
- `mac_mii_rxd`  out  4  MII nibble; low dibit in [1:0].
- `mac_mii_rxdv`  out  1  nibble belongs to a frame.
- `mac_mii_rxer`  out  1  RX_ER seen on either dibit of the nibble.
- `mac_mii_rxce`  out  1  one-cycle strobe: nibble outputs updated this cycle.

## Operation
- Input stage: `phy_rmii_crsdv`, `phy_rmii_rxer` and `phy_rmii_rxd` are registered once. All decisions use the registered values.
- Sample strobe:
  - 100M: asserted every cycle.
  - 10M: mod-10 counter. Cleared to 0 on the first IDLE cycle that sees registered CRS_DV = 1. Strobe fires at count 4, mid-dibit.
  - All FSM activity occurs on strobe cycles only.
- FSM (3 states):
  - IDLE:
    - Latches `mode_speed`.
    - CRS_DV = 1 → PREAMBLE.
  - PREAMBLE:
    - rxd 00 is ignored.
    - rxd = 01 with CRS_DV = 1 → DATA, phase = 1. This dibit is stored as the low half.
    - CRS_DV = 0 on two consecutive strobes → IDLE, with no `rxce` emitted.
  - DATA:
    - Phase 0 stores the low dibit, its CRS_DV and its RX_ER.
    - Phase 1 completes the nibble.
    - If CRS_DV was 0 on both dibits: emit the terminating nibble (`rxdv` = 0, `rxd` = 0, `rxer` = 0, `rxce` = 1), then → IDLE.
    - Otherwise: emit `rxd` = {high, low}, `rxdv` = 1, `rxer` = OR of both RX_ER samples.
    - Phase toggles on every strobe.
- CRS_DV toggle rule: CRS_DV low on only one dibit of a nibble (carrier lost, data still draining) does not end the frame.
- Preamble 0x5 / SFD 0xD are passed through unchanged; the MAC strips them.

## Timing
- Reset: when `rstn` is low at a clock edge, the next cycle has:
  - state IDLE, phase 0, 10M counter 0;
  - `mac_mii_rxd` = 0, `mac_mii_rxdv`, `mac_mii_rxer` and `mac_mii_rxce` = 0.
- Reset mid-frame: the frame is truncated silently. No terminating nibble is emitted.
- Latency:
  - 100M: `rxce` pulses 2 cycles after the high dibit is on the pins.
  - 10M: `rxce` pulses 2 cycles after the phase-1 strobe sample.
- `rxce` period:
  - 100M: exactly 2 cycles.
  - 10M: exactly 20 cycles.
  - `rxce` is never asserted in IDLE or PREAMBLE.
- `rxd`, `rxdv` and `rxer` are registered and hold their values between `rxce` pulses.
- `mode_speed` changes outside IDLE take effect at the next frame.

## Configuration
- `RMII_RX_10M_EN`:
  - Defined: the 10M divider is built and `mode_speed` is honoured as above.
  - Undefined: the divider logic is omitted, `mode_speed` is ignored and the block always runs at 100M (strobe every cycle).

## Test plan
- 100M frame: 7×0x5, 0xD, then bytes 0x12 0x34 with CRS_DV solid → `rxce` every 2 cycles; nibbles 5×7, D, 2, 1, 4, 3 with `rxdv` = 1; then one `rxce` with `rxdv` = 0.
- 10M (`RMII_RX_10M_EN` defined, `mode_speed` = 0), each dibit held 10 cycles → same nibble sequence, `rxce` spacing 20 cycles.
- End-of-frame toggle: CRS_DV low on the low dibit and high on the high dibit for the last 3 nibbles, then low on both → all 3 nibbles emitted with `rxdv` = 1; the frame ends on the both-low nibble.
- RX_ER asserted on the high dibit of data nibble 0xA → that nibble has `rxer` = 1; neighbouring nibbles have `rxer` = 0.
- False start: CRS_DV high with rxd 00 for 4 dibits, then low for 2 strobes → no `rxce`; state returns to IDLE and the next frame decodes correctly.
- Reset mid-frame: `rstn` = 0 after 6 data nibbles → all outputs 0 on the next cycle and no terminating nibble; a subsequent frame decodes correctly.
